// File: rtl/fetch_unit_pkg.sv
// Shared types for the VeriRISC fetch unit: opcode encoding, fetch FSM states
// and the opcode field width.
package fetch_unit_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Controller <-> fetch unit signal bundle. The pc_wrap flag exists only when
// IFU_PC_WRAP_EN is defined.
interface fetch_unit_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  import fetch_unit_pkg::*;

  logic              load_ir;
  logic              inc_pc;
  logic              load_pc;
  logic              halt;
  logic              mem_rd;
  logic              fetch;
  logic              mem_ready;
  logic [DWIDTH-1:0] data_in;
  opcode_t           opcode;
  logic [AWIDTH-1:0] ir_addr;
  logic [AWIDTH-1:0] pc_addr;
  logic [AWIDTH-1:0] addr;
  logic              stall;
  logic              ir_valid;
  logic              halted;
`ifdef IFU_PC_WRAP_EN
  logic              pc_wrap;
`endif

  modport master (
    output load_ir, inc_pc, load_pc, halt, mem_rd, fetch, mem_ready, data_in,
`ifdef IFU_PC_WRAP_EN
    input  pc_wrap,
`endif
    input  opcode, ir_addr, pc_addr, addr, stall, ir_valid, halted
  );

  modport slave (
    input  load_ir, inc_pc, load_pc, halt, mem_rd, fetch, mem_ready, data_in,
`ifdef IFU_PC_WRAP_EN
    output pc_wrap,
`endif
    output opcode, ir_addr, pc_addr, addr, stall, ir_valid, halted
  );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Loadable program counter with asynchronous reset; load wins over increment,
// and wrap pulses on the edge where an increment rolls all-ones over to zero.
module pc_counter #(
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [AWIDTH-1:0] d,
  output logic [AWIDTH-1:0] count,
  output logic              wrap
);

  logic [AWIDTH-1:0] count_q;
  logic [AWIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = d;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = inc & ~load & (&count_q);

endmodule

// File: rtl/fetch_unit.sv
// VeriRISC fetch unit: PC, instruction register, address mux and memory-ready
// stall FSM. Define IFU_PC_WRAP_EN to add the sticky pc_wrap flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.slave bus
);

  ifu_state_t        state_q, state_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [AWIDTH-1:0] pc;
  logic [AWIDTH-1:0] ir_addr;
  logic              stall;
  logic              upd_en;
  logic              ir_load;
  logic              wrap_evt;

  assign ir_addr = ir_q[AWIDTH-1:0];
  assign stall   = bus.mem_rd & ~bus.mem_ready & (state_q != HALTED);
  assign upd_en  = ~stall & (state_q != HALTED);
  assign ir_load = bus.load_ir & bus.mem_ready & upd_en;

  // Jump target is the pre-edge operand, even when IR reloads on the same edge.
  pc_counter #(.AWIDTH(AWIDTH)) u_pc (
    .clk   (clk),
    .rst   (rst),
    .load  (bus.load_pc & upd_en),
    .inc   (bus.inc_pc & upd_en),
    .d     (ir_addr),
    .count (pc),
    .wrap  (wrap_evt)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.mem_rd && !bus.mem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.mem_ready) begin
          state_d = IDLE;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
    if (ir_load) begin
      ir_d       = bus.data_in;
      ir_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

`ifdef IFU_PC_WRAP_EN
  logic pc_wrap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_wrap_q <= 1'b0;
    end else if (wrap_evt) begin
      pc_wrap_q <= 1'b1;
    end
  end

  assign bus.pc_wrap = pc_wrap_q;
`else
  logic wrap_unused;
  assign wrap_unused = wrap_evt;
`endif

  assign bus.opcode   = opcode_t'(ir_q[DWIDTH-1 -: OPC_W]);
  assign bus.ir_addr  = ir_addr;
  assign bus.pc_addr  = pc;
  assign bus.addr     = bus.fetch ? pc : ir_addr;
  assign bus.stall    = stall;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted   = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each step queues the expected post-edge
// state, and a monitor compares it one time unit after the rising edge.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    int         pc;
    logic [7:0] ir;
    bit         irv;
    bit         hlt;
    bit         wrap;
  } exp_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  fetch_unit_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

  fetch_unit #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic exp_t mk(input int pc, input logic [7:0] ir, input bit irv,
                              input bit hlt, input bit wrap);
    exp_t e;
    e.pc = pc; e.ir = ir; e.irv = irv; e.hlt = hlt; e.wrap = wrap;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val("pc",       bus.pc_addr,  e.pc);
      check_val("opcode",   bus.opcode,   e.ir[7:5]);
      check_val("ir_addr",  bus.ir_addr,  e.ir[4:0]);
      check_val("ir_valid", bus.ir_valid, e.irv);
      check_val("halted",   bus.halted,   e.hlt);
`ifdef IFU_PC_WRAP_EN
      check_val("pc_wrap",  bus.pc_wrap,  e.wrap);
`endif
    end
  end

  task automatic step(input bit li, input bit ip, input bit lp, input bit h,
                      input bit mr, input bit f, input bit rdy, input logic [7:0] d,
                      input int exp_addr, input bit exp_stall, input exp_t e);
    bus.load_ir = li; bus.inc_pc = ip; bus.load_pc = lp; bus.halt = h;
    bus.mem_rd = mr; bus.fetch = f; bus.mem_ready = rdy; bus.data_in = d;
    #1;
    check_val("stall_pre", bus.stall, exp_stall);
    check_val("addr_pre",  bus.addr,  exp_addr);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.load_ir = 0; bus.inc_pc = 0; bus.load_pc = 0; bus.halt = 0;
    bus.mem_rd = 0; bus.fetch = 1; bus.mem_ready = 0; bus.data_in = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    check_val("rst_pc",     bus.pc_addr,  0);
    check_val("rst_opcode", bus.opcode,   HLT);
    check_val("rst_iraddr", bus.ir_addr,  0);
    check_val("rst_irv",    bus.ir_valid, 0);
    check_val("rst_halted", bus.halted,   0);
    check_val("rst_stall",  bus.stall,    0);
    check_val("rst_addr",   bus.addr,     0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Build PC=9, IR=E3, then enter a wait state and reset mid-read.
    step(1,0,0,0,1,1,1,8'h09,  0,0, mk(0, 8'h09,1,0,0));
    step(0,0,1,0,0,1,0,8'h00,  0,0, mk(9, 8'h09,1,0,0));
    step(1,0,0,0,1,1,1,8'hE3,  9,0, mk(9, 8'hE3,1,0,0));
    step(0,0,0,0,1,1,0,8'h00,  9,1, mk(9, 8'hE3,1,0,0));
    rst = 1'b1;
    #1;
    check_val("mid_rst_pc",     bus.pc_addr,  0);
    check_val("mid_rst_opcode", bus.opcode,   HLT);
    check_val("mid_rst_irv",    bus.ir_valid, 0);
    check_val("mid_rst_halted", bus.halted,   0);
    idle_inputs();
    #1;
    check_val("mid_rst_stall", bus.stall, 0);
    check_val("mid_rst_addr",  bus.addr,  0);
    rst = 1'b0;

    // Zero-wait fetch from PC=3 of LDA 10, then addr mux on operand.
    step(1,0,0,0,1,1,1,8'h03,  0,0, mk(3'd0,8'h03,1,0,0));
    step(0,0,1,0,0,1,0,8'h00,  0,0, mk(3, 8'h03,1,0,0));
    step(1,0,0,0,1,1,1,8'hAA,  3,0, mk(3, 8'hAA,1,0,0));
    step(0,0,0,0,0,0,0,8'h00, 10,0, mk(3, 8'hAA,1,0,0));

    // Three wait cycles with inc_pc held, then data arrives.
    for (int i = 0; i < 3; i++) begin
      step(1,1,0,0,1,1,0,8'h3F, 3,1, mk(3, 8'hAA,1,0,0));
    end
    step(1,1,0,0,1,1,1,8'h3F,  3,0, mk(4, 8'h3F,1,0,0));

    // Jump priority, then jump + IR load on the same edge uses the old operand.
    step(1,0,0,0,1,1,1,8'h11,  4,0, mk(4, 8'h11,1,0,0));
    step(0,1,1,0,0,1,0,8'h00,  4,0, mk(17,8'h11,1,0,0));
    step(1,0,1,0,1,1,1,8'h1F, 17,0, mk(17,8'h1F,1,0,0));

    // Wrap 31 -> 0; the sticky flag stays set afterwards.
    step(0,0,1,0,0,1,0,8'h00, 17,0, mk(31,8'h1F,1,0,0));
    step(0,1,0,0,0,1,0,8'h00, 31,0, mk(0, 8'h1F,1,0,1));
    step(0,1,0,0,0,1,0,8'h00,  0,0, mk(1, 8'h1F,1,0,1));

    // Halt freezes everything and suppresses stall.
    step(0,0,0,1,0,1,0,8'h00,  1,0, mk(1, 8'h1F,1,1,1));
    step(1,1,0,0,1,1,0,8'hFF,  1,0, mk(1, 8'h1F,1,1,1));
    step(1,1,1,0,1,1,1,8'hFF,  1,0, mk(1, 8'h1F,1,1,1));

    idle_inputs();
    rst = 1'b1;
    #1;
    check_val("end_rst_halted", bus.halted,   0);
    check_val("end_rst_pc",     bus.pc_addr,  0);
    check_val("end_rst_irv",    bus.ir_valid, 0);
`ifdef IFU_PC_WRAP_EN
    check_val("end_rst_wrap",   bus.pc_wrap,  0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #3;
    check_val("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
